// File: rtl/baby_ram_arbiter.sv
// baby_ram_arbiter: shares the 32 x 32 program/data store between the
// Manchester Baby core and a host loader/debug port.
//
// The host gets bounded bursts of store access. While the host owns the store,
// the core is held through core_stall_o, so the chip clock keeps running.
//
// Ports:
//   clock, reset_i          design clock, async active-high reset
//   core_addr_i/rw_en_i/data_i   core-side store request
//   core_data_o             store read data to the core (always passed through)
//   core_stall_o            core must hold state this cycle
//   host_req_i/we_i/addr_i/wdata_i  host transfer request, held until accepted
//   host_gnt_o              host owns the store this cycle
//   host_rdata_o/rvalid_o   registered host read data and its one-cycle strobe
//   mem_addr_o/we_o/wdata_o physical store request
//   mem_rdata_i             store read data, combinational from mem_addr_o
module baby_ram_arbiter #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned HOST_BURST = 4
) (
    input  logic              clock,
    input  logic              reset_i,

    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic              core_rw_en_i,
    input  logic [DATA_W-1:0] core_data_i,
    output logic [DATA_W-1:0] core_data_o,
    output logic              core_stall_o,

    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_rvalid_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned CNT_W = 4;
    // Count value at which the next transfer completes a full burst.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOST_BURST - 1);

    typedef enum logic [1:0] {
        S_CORE  = 2'd0,
        S_HOST  = 2'd1,
        S_YIELD = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             xfer;

    // A transfer happens on any edge where the host owns the store and requests.
    assign xfer = (state == S_HOST) && host_req_i;

    // Store mux: ownership comes from the registered grant, never from host_req_i.
    always_comb begin
        mem_addr_o  = core_addr_i;
        mem_wdata_o = core_data_i;
        mem_we_o    = core_rw_en_i;
        if (host_gnt_o) begin
            mem_addr_o  = host_addr_i;
            mem_wdata_o = host_wdata_i;
            mem_we_o    = host_req_i & host_we_i;
        end
    end

    // The core simply ignores read data while it is stalled.
    assign core_data_o = mem_rdata_i;

    // Ownership FSM with burst counter and registered host read return.
    // host_gnt_o and core_stall_o are flops that track (next state == HOST).
    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state         <= S_CORE;
            count         <= '0;
            host_gnt_o    <= 1'b0;
            core_stall_o  <= 1'b0;
            host_rvalid_o <= 1'b0;
            host_rdata_o  <= '0;
        end else begin
            host_rvalid_o <= xfer && !host_we_i;
            if (xfer && !host_we_i) begin
                host_rdata_o <= mem_rdata_i;
            end

            case (state)
                S_CORE: begin
                    // The core finishes its current cycle; the grant starts next cycle.
                    if (host_req_i) begin
                        state        <= S_HOST;
                        host_gnt_o   <= 1'b1;
                        core_stall_o <= 1'b1;
                    end
                end
                S_HOST: begin
                    if (!host_req_i) begin
                        // Idle grant cycle: hand the store back to the core.
                        state        <= S_CORE;
                        count        <= '0;
                        host_gnt_o   <= 1'b0;
                        core_stall_o <= 1'b0;
                    end else if (count == LAST_CNT) begin
                        // Burst exhausted: force one core cycle.
                        state        <= S_YIELD;
                        count        <= '0;
                        host_gnt_o   <= 1'b0;
                        core_stall_o <= 1'b0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                S_YIELD: begin
                    if (host_req_i) begin
                        state        <= S_HOST;
                        host_gnt_o   <= 1'b1;
                        core_stall_o <= 1'b1;
                    end else begin
                        state <= S_CORE;
                    end
                end
                default: begin
                    state        <= S_CORE;
                    count        <= '0;
                    host_gnt_o   <= 1'b0;
                    core_stall_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baby_ram_arbiter.sv
// Directed bench for baby_ram_arbiter with a behavioural 32 x 32 store and
// a read-data scoreboard queue.
module tb_baby_ram_arbiter;

    logic        clock;
    logic        reset_i;
    logic [4:0]  core_addr;
    logic        core_rw_en;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        host_req;
    logic        host_we;
    logic [4:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] store   [32];
    logic [31:0] exp_mem [32];
    logic [31:0] rq [$];
    int          n_tests;
    int          n_fail;

    // Expected core_stall_o samples for the 10-write burst, index 0 first.
    logic [14:0] exp_pat = 15'b011101111011110;

    baby_ram_arbiter #(
        .ADDR_W     (5),
        .DATA_W     (32),
        .HOST_BURST (4)
    ) dut (
        .clock         (clock),
        .reset_i       (reset_i),
        .core_addr_i   (core_addr),
        .core_rw_en_i  (core_rw_en),
        .core_data_i   (core_wdata),
        .core_data_o   (core_rdata),
        .core_stall_o  (core_stall),
        .host_req_i    (host_req),
        .host_we_i     (host_we),
        .host_addr_i   (host_addr),
        .host_wdata_i  (host_wdata),
        .host_gnt_o    (host_gnt),
        .host_rdata_o  (host_rdata),
        .host_rvalid_o (host_rvalid),
        .mem_addr_o    (mem_addr),
        .mem_we_o      (mem_we),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata)
    );

    always #5 clock = ~clock;

    // Physical store: synchronous write, combinational read.
    always @(posedge clock) begin
        if (mem_we) store[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = store[mem_addr];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] burst_word(input int i);
        return 32'h5A00_0000 | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; drain read returns.
    task automatic tick();
        @(posedge clock);
        #1;
        if (host_rvalid) begin
            if (rq.size() == 0) chk("rvalid_spurious", 32'(host_rvalid), 32'd0);
            else                chk("host_rdata", host_rdata, rq.pop_front());
        end
    endtask

    initial begin
        int  n;
        int  stalls;
        logic pend;

        n_tests    = 0;
        n_fail     = 0;
        clock      = 1'b0;
        reset_i    = 1'b0;
        core_addr  = '0;
        core_rw_en = 1'b0;
        core_wdata = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;

        // Reset state
        #2 reset_i = 1'b1;
        #1;
        chk("rst_gnt",    32'(host_gnt),    32'd0);
        chk("rst_stall",  32'(core_stall),  32'd0);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_rdata",  host_rdata,       32'd0);
        tick();
        tick();
        reset_i = 1'b0;

        // Preload the store through the core path
        for (int i = 0; i < 32; i++) begin
            core_addr  = 5'(i);
            core_rw_en = 1'b1;
            core_wdata = (i == 7) ? 32'h0000_1234 : (32'h1000_0000 | 32'(i));
            exp_mem[i] = core_wdata;
            tick();
        end
        core_rw_en = 1'b0;
        core_addr  = 5'd7;
        #1;
        chk("core_read_w7", core_rdata, exp_mem[7]);
        chk("core_idle_stall", 32'(core_stall), 32'd0);

        // Core write to word 31 on the same cycle the host requests a write to word 5
        core_addr  = 5'd31;
        core_rw_en = 1'b1;
        core_wdata = 32'hA5A5_A5A5;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'd5;
        host_wdata = 32'hDEAD_BEEF;
        #1;
        chk("core_wr_we",   32'(mem_we),   32'd1);
        chk("core_wr_addr", 32'(mem_addr), 32'd31);
        chk("core_wr_gnt",  32'(host_gnt), 32'd0);
        stalls = 0;
        tick();
        exp_mem[31] = 32'hA5A5_A5A5;
        core_rw_en  = 1'b0;
        stalls += int'(core_stall);
        chk("core_w31_landed", store[31], exp_mem[31]);
        chk("hw_gnt_rise",     32'(host_gnt), 32'd1);
        chk("hw_mem_addr",     32'(mem_addr), 32'd5);
        chk("hw_mem_we",       32'(mem_we),   32'd1);
        tick();
        exp_mem[5] = 32'hDEAD_BEEF;
        host_req   = 1'b0;
        #1;
        stalls += int'(core_stall);
        chk("hw_w5",        store[5], exp_mem[5]);
        chk("hw_idle_gnt",  32'(host_gnt), 32'd1);
        chk("hw_idle_we",   32'(mem_we),   32'd0);
        tick();
        stalls += int'(core_stall);
        chk("hw_back_core", 32'(host_gnt), 32'd0);
        chk("hw_stall_cycles", 32'(stalls), 32'd2);

        // Host read of word 7
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 5'd7;
        rq.push_back(exp_mem[7]);
        tick();
        chk("rd_gnt", 32'(host_gnt), 32'd1);
        chk("rd_rvalid_early", 32'(host_rvalid), 32'd0);
        tick();
        host_req = 1'b0;
        chk("rd_rvalid_pulse", 32'(host_rvalid), 32'd1);
        chk("rd_rdata_w7", host_rdata, 32'h0000_1234);
        tick();
        chk("rd_rvalid_drop", 32'(host_rvalid), 32'd0);
        tick();

        // Read-after-write on word 3
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'd3;
        host_wdata = 32'hCAFE_F00D;
        tick();
        tick();
        exp_mem[3] = 32'hCAFE_F00D;
        host_we    = 1'b0;
        rq.push_back(exp_mem[3]);
        tick();
        host_req = 1'b0;
        chk("raw_rdata", host_rdata, 32'hCAFE_F00D);
        tick();
        tick();
        chk("raw_rq_drained", 32'(rq.size()), 32'd0);

        // Burst fairness: 10 host writes to words 0..9
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'd0;
        host_wdata = burst_word(0);
        n = 0;
        chk("stall_0", 32'(core_stall), 32'(exp_pat[0]));
        for (int c = 1; c < 15; c++) begin
            pend = host_gnt && host_req;
            tick();
            if (pend) begin
                exp_mem[host_addr] = host_wdata;
                n++;
                if (n == 10) begin
                    host_req = 1'b0;
                end else begin
                    host_addr  = 5'(n);
                    host_wdata = burst_word(n);
                end
            end
            chk($sformatf("stall_%0d", c), 32'(core_stall), 32'(exp_pat[c]));
        end
        chk("burst_count", 32'(n), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("burst_w%0d", i), store[i], burst_word(i));
        end
        chk("burst_w10_untouched", store[10], exp_mem[10]);

        // Host drops request right after asking: one idle grant cycle, then back to core
        host_req  = 1'b1;
        host_we   = 1'b1;
        host_addr = 5'd12;
        host_wdata = 32'h1111_2222;
        tick();
        host_req = 1'b0;
        #1;
        chk("drop_gnt", 32'(host_gnt), 32'd1);
        chk("drop_we",  32'(mem_we),   32'd0);
        tick();
        chk("drop_core", 32'(core_stall), 32'd0);
        chk("drop_w12",  store[12], exp_mem[12]);

        // Reset mid-burst with a pending host write to word 9
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'd9;
        host_wdata = 32'hBAD0_BAD0;
        tick();
        chk("mid_gnt",   32'(host_gnt), 32'd1);
        chk("mid_we_on", 32'(mem_we),   32'd1);
        reset_i = 1'b1;
        #1;
        chk("mid_rst_gnt",   32'(host_gnt),   32'd0);
        chk("mid_rst_stall", 32'(core_stall), 32'd0);
        chk("mid_rst_we",    32'(mem_we),     32'd0);
        tick();
        chk("mid_rst_w9", store[9], exp_mem[9]);
        host_req = 1'b0;
        reset_i  = 1'b0;
        tick();
        chk("mid_rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("final_rq_drained", 32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/baby_ram_arbiter.md
Name: baby_ram_arbiter

Overview:
- Shares the single 32-word x 32-bit program/data store between the Manchester Baby core and a host loader/debug port.
- Sits between the core's ram_* bus and the physical store.
- Grants the host bounded bursts of access while stalling the core through a clock-enable, so programs can be loaded and inspected without stopping the chip clock.

Parameters:
- ADDR_W, 5, store address width (32 words)
- DATA_W, 32, word width
- HOST_BURST, 4, max consecutive host transfers before the core is given one cycle (range 1..15)

Ports:
- clock  in  1  single design clock
- reset_i  in  1  asynchronous, active-high reset
- core_addr_i  in  ADDR_W  core word address
- core_rw_en_i  in  1  core write strobe (0 = read, 1 = write)
- core_data_i  in  DATA_W  core write data
- core_data_o  out  DATA_W  read data to core
- core_stall_o  out  1  1 = core must hold state this cycle
- host_req_i  in  1  host transfer request, held until accepted
- host_we_i  in  1  host write (1) / read (0)
- host_addr_i  in  ADDR_W  host word address
- host_wdata_i  in  DATA_W  host write data
- host_gnt_o  out  1  host owns store this cycle
- host_rdata_o  out  DATA_W  registered host read data
- host_rvalid_o  out  1  one-cycle pulse, host_rdata_o valid
- mem_addr_o  out  ADDR_W  store address
- mem_we_o  out  1  store write enable
- mem_wdata_o  out  DATA_W  store write data
- mem_rdata_i  in  DATA_W  store read data, combinational from mem_addr_o

Behaviour:
- Reset (async, immediate):
  - state=CORE, burst count=0.
  - host_gnt_o=0, core_stall_o=0, host_rvalid_o=0, host_rdata_o=0.
  - Any in-flight host transfer is dropped; no write is issued.
- States:
  - CORE: core owns the store.
  - HOST: host owns the store.
  - YIELD: one forced core cycle after a full burst.
- Outputs by state (all decoded from the state register only, never from host_req_i):
  - CORE: mem_* = core_*; core_stall_o=0; host_gnt_o=0.
  - HOST: mem_addr_o/mem_wdata_o = host_*; mem_we_o = host_req_i & host_we_i; core_stall_o=1; host_gnt_o=1.
  - YIELD: same as CORE.
  - core_data_o = mem_rdata_i in all states; the core ignores it while stalled.
- Transfer: a host transfer occurs on a rising edge where state=HOST and host_req_i=1.
  - Write: the store is written at that edge.
  - Read: host_rdata_o <= mem_rdata_i at that edge; host_rvalid_o=1 for exactly the following cycle.
- Transitions (evaluated at the rising edge):
  - CORE -> HOST when host_req_i=1. First grant is the next cycle, so the core finishes its current cycle; its write, if any, completes first.
  - HOST -> CORE when host_req_i=0 (idle grant cycle, no transfer). Count clears.
  - HOST -> YIELD when a transfer occurs and count+1 = HOST_BURST. Count clears.
  - HOST -> HOST on any other transfer; count increments.
  - YIELD -> HOST if host_req_i=1, else YIELD -> CORE. YIELD always lasts exactly 1 cycle.
  - Core is therefore never stalled more than HOST_BURST+1 consecutive cycles.
- Host protocol:
  - Addr/we/wdata must be stable while host_req_i=1 and until the transfer edge.
  - Back-to-back transfers: hold host_req_i high and change fields after each accepted edge.
  - Host dropping req before the grant edge is legal; the arbiter returns to CORE after one idle HOST cycle.
- Widths: counter is 4 bits; no arithmetic on data paths.

Test Plan:
- Reset mid-burst:
  - Stimulus: assert reset_i during HOST state with host_we_i=1.
  - Required: host_gnt_o=0 and core_stall_o=0 immediately; mem_we_o=0; the target word is unchanged.
- Single host write:
  - Stimulus: from CORE, hold host_req_i=1, we=1, addr=5, wdata=0xDEADBEEF.
  - Required: gnt rises 1 cycle later; write occurs at that edge; drop req -> one idle HOST cycle, then CORE; word 5 = 0xDEADBEEF; core stalled exactly 2 cycles.
- Host read:
  - Stimulus: word 7 preloaded = 0x0000_1234; host reads addr 7.
  - Required: host_rvalid_o pulses exactly 1 cycle after the transfer edge with host_rdata_o=0x00001234.
- Burst fairness:
  - Stimulus: HOST_BURST=4; host holds req for 10 writes to addr 0..9.
  - Required: core_stall_o pattern is 0,1,1,1,1,0,1,1,1,1,0,1,1,1 (…); all 10 words written in order.
- Core traffic unaffected:
  - Stimulus: core writes 0xA5A5A5A5 to addr 31 on the cycle host_req_i rises.
  - Required: the core write lands; host grant begins the next cycle.
- Read-after-write:
  - Stimulus: host writes addr 3 then immediately reads addr 3.
  - Required: host_rdata_o equals the written value.
